// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorter front end: FSM state encoding,
// default frame geometry and the sort-neutral pad value.
package sort_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PAD  = 1'b1
  } state_e;

  localparam int DEFAULT_LOG_INPUT_NUM = 5;
  localparam int DEFAULT_N             = 1 << DEFAULT_LOG_INPUT_NUM;

  // Widest element the pad helper can describe; callers slice the low bits.
  localparam int PAD_MAX_W = 128;

  // Value that sorts after every real element for the given interpretation.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input logic is_signed,
                                                     input logic ascending,
                                                     input int   data_width);
    logic [PAD_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < PAD_MAX_W; i++) begin
      if (i < data_width) begin
        if (ascending) v[i] = !(is_signed && (i == data_width - 1));
        else           v[i] =   is_signed && (i == data_width - 1);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sort_frame_loader.sv
// Streaming loader: gathers 2**LOG_INPUT_NUM elements into an assembly buffer,
// pads short frames, and presents each completed frame with a one-cycle strobe.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int LOG_INPUT_NUM = DEFAULT_LOG_INPUT_NUM,
  parameter int DATA_WIDTH    = 32,
  parameter int SIGNED        = 0,
  parameter int ASCENDING     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic                                   in_last,
  output logic                                   x_valid,
  output logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0] x,
  output logic [LOG_INPUT_NUM:0]                 x_count,
  output state_e                                 dbg_state
);

  localparam int N  = 1 << LOG_INPUT_NUM;
  localparam int PW = LOG_INPUT_NUM;
  localparam int CW = LOG_INPUT_NUM + 1;
  localparam logic [PAD_MAX_W-1:0] PAD_FULL =
    pad_value(SIGNED != 0, ASCENDING != 0, DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PAD_VAL = PAD_FULL[DATA_WIDTH-1:0];
  localparam logic [PW-1:0] LAST_SLOT = PW'(N - 1);

  // Handshake: an element moves on any rising edge where in_valid && in_ready;
  // the source must hold in_data/in_last stable while in_ready is low.

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    x_valid_q;
  logic [DATA_WIDTH*N-1:0] x_q;
  logic [CW-1:0]           x_count_q;

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    complete;
  logic [DATA_WIDTH*N-1:0] frame_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_data  = in_data;
    complete = 1'b0;
    in_ready = !rst && (state_q == FILL);
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          cnt_d = CW'(ptr_q) + CW'(1);
          if (ptr_q == LAST_SLOT) begin
            complete = 1'b1;
          end else begin
            ptr_d = ptr_q + PW'(1);
            if (in_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = PAD_VAL;
        if (ptr_q == LAST_SLOT) complete = 1'b1;
        else                    ptr_d    = ptr_q + PW'(1);
      end
      default: state_d = FILL;
    endcase
    if (complete) begin
      ptr_d   = '0;
      state_d = FILL;
    end
  end

  // Each slot updates only when addressed; frame_d is the buffer as it will
  // look after this edge, so a completing write lands in x on the same edge.
  for (genvar i = 0; i < N; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;
    logic                  slot_en;
    assign slot_en = wr_en && (ptr_q == PW'(i));
    assign frame_d[DATA_WIDTH*i +: DATA_WIDTH] = slot_en ? wr_data : slot_q;
    always_ff @(posedge clk) begin
      if (slot_en) slot_q <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      ptr_q     <= '0;
      cnt_q     <= '0;
      x_valid_q <= 1'b0;
      x_q       <= '0;
      x_count_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      x_valid_q <= complete;
      if (complete) begin
        x_q       <= frame_d;
        x_count_q <= cnt_d;
      end
    end
  end

  assign x_valid   = x_valid_q;
  assign x         = x_q;
  assign x_count   = x_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader with N = 4: three instances share the
// stimulus and differ only in pad value (asc/unsigned, asc/signed, desc/unsigned).
module tb_sort_frame_loader;
  import sort_pkg::*;

  localparam int LOGN = 2;
  localparam int DW   = 32;
  localparam int N    = 1 << LOGN;
  localparam int XW   = DW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] in_data;

  logic          rdy0, rdy1, rdy2;
  logic          xv0, xv1, xv2;
  logic [XW-1:0] x0, x1, x2;
  logic [LOGN:0] xc0, xc1, xc2;
  state_e        st0, st1, st2;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] vals [12];

  always #5 clk = ~clk;

  sort_frame_loader #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(DW), .SIGNED(0), .ASCENDING(1)) u_au (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .x_valid(xv0), .x(x0), .x_count(xc0), .dbg_state(st0));
  sort_frame_loader #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(DW), .SIGNED(1), .ASCENDING(1)) u_as (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .x_valid(xv1), .x(x1), .x_count(xc1), .dbg_state(st1));
  sort_frame_loader #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(DW), .SIGNED(0), .ASCENDING(0)) u_du (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .x_valid(xv2), .x(x2), .x_count(xc2), .dbg_state(st2));

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b0;

    // 1. reset with in_valid held high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready",   XW'(rdy0), XW'(1'b0));
      chk("rst_xvalid",  XW'(xv0),  XW'(1'b0));
      chk("rst_x",       x0,        '0);
      chk("rst_xcount",  XW'(xc0),  '0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_ready", XW'(rdy0), XW'(1'b1));
    chk("post_rst_state", XW'(st0),  XW'(FILL));

    // 2. full frame 5,1,9,3
    tick();
    drive(1'b1, 32'h5, 1'b0);
    chk("f2_no_early_valid", XW'(xv0), XW'(1'b0));
    drive(1'b1, 32'h1, 1'b0);
    drive(1'b1, 32'h9, 1'b0);
    drive(1'b1, 32'h3, 1'b0);
    in_valid = 1'b0;
    chk("f2_xvalid", XW'(xv0), XW'(1'b1));
    chk("f2_x",      x0, {32'h3, 32'h9, 32'h1, 32'h5});
    chk("f2_xcount", XW'(xc0), XW'(3'd4));
    tick();
    chk("f2_xvalid_clear", XW'(xv0), XW'(1'b0));
    chk("f2_x_hold",       x0, {32'h3, 32'h9, 32'h1, 32'h5});

    // 3. short frame 7,2 with in_last; source keeps offering data during PAD
    drive(1'b1, 32'h7, 1'b0);
    drive(1'b1, 32'h2, 1'b1);
    in_data = 32'hAAAA_AAAA; in_last = 1'b0;
    chk("f3_pad_ready0", XW'(rdy0), XW'(1'b0));
    chk("f3_pad_state",  XW'(st0),  XW'(PAD));
    tick();
    chk("f3_pad_ready1", XW'(rdy0), XW'(1'b0));
    chk("f3_pad_novalid", XW'(xv0), XW'(1'b0));
    tick();
    in_valid = 1'b0;
    chk("f3_xvalid",     XW'(xv0), XW'(1'b1));
    chk("f3_ready_back", XW'(rdy0), XW'(1'b1));
    chk("f3_x_au", x0, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h7});
    chk("f3_xcount_au", XW'(xc0), XW'(3'd2));
    chk("f3_x_as", x1, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2, 32'h7});
    chk("f3_xcount_as", XW'(xc1), XW'(3'd2));
    chk("f3_x_du", x2, {32'h0, 32'h0, 32'h2, 32'h7});
    chk("f3_xcount_du", XW'(xc2), XW'(3'd2));
    tick();
    chk("f3_xvalid_clear", XW'(xv0), XW'(1'b0));

    // 4. three back-to-back full frames
    vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66,
             32'h77, 32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC};
    for (int c = 0; c < 12; c++) begin
      chk("f4_ready", XW'(rdy0), XW'(1'b1));
      drive(1'b1, vals[c], 1'b0);
      if (c % 4 == 3) begin
        chk("f4_xvalid", XW'(xv0), XW'(1'b1));
        chk("f4_x", x0, {vals[c], vals[c-1], vals[c-2], vals[c-3]});
        chk("f4_xcount", XW'(xc0), XW'(3'd4));
      end else begin
        chk("f4_xvalid_low", XW'(xv0), XW'(1'b0));
      end
    end
    in_valid = 1'b0;
    tick();

    // 5. in_valid toggling; in_last on a full frame adds no padding
    drive(1'b1, 32'h21, 1'b0);
    drive(1'b0, 32'hBAD0, 1'b1);
    chk("f5_idle_novalid", XW'(xv0), XW'(1'b0));
    drive(1'b1, 32'h22, 1'b0);
    drive(1'b0, 32'hBAD1, 1'b0);
    drive(1'b1, 32'h23, 1'b0);
    drive(1'b0, 32'hBAD2, 1'b1);
    chk("f5_still_fill", XW'(rdy0), XW'(1'b1));
    drive(1'b1, 32'h24, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("f5_xvalid", XW'(xv0), XW'(1'b1));
    chk("f5_x",      x0, {32'h24, 32'h23, 32'h22, 32'h21});
    chk("f5_xcount", XW'(xc0), XW'(3'd4));
    tick();
    chk("f5_state_fill", XW'(st0), XW'(FILL));

    // 6. reset during PAD discards the partial frame
    drive(1'b1, 32'h31, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f6_rst_novalid", XW'(xv0), XW'(1'b0));
    chk("f6_rst_xcount",  XW'(xc0), '0);
    chk("f6_rst_state",   XW'(st0), XW'(FILL));
    tick();
    chk("f6_novalid_late", XW'(xv0), XW'(1'b0));
    tick();
    drive(1'b1, 32'h41, 1'b0);
    drive(1'b1, 32'h42, 1'b0);
    drive(1'b1, 32'h43, 1'b0);
    drive(1'b1, 32'h44, 1'b0);
    in_valid = 1'b0;
    chk("f6_xvalid", XW'(xv0), XW'(1'b1));
    chk("f6_x",      x0, {32'h44, 32'h43, 32'h42, 32'h41});
    chk("f6_xcount", XW'(xc0), XW'(3'd4));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
